// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helper for the round engine.
package aes_pkg;

  localparam int NR       = 10;
  localparam int RK_IDX_W = 4;
  localparam int NB       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Source byte for each ShiftRows output byte; byte 0 is the MSB of the state.
  localparam logic [0:NB-1][3:0] SR_SRC = 64'h05AF_49E3_8D27_C16B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on last), AddRoundKey.
module aes_round_dp
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] nxt
);

  logic [0:NB-1][7:0] sb, sr, mc;

  aes_sub_bytes u_sub (.a(st), .y(sb));

  for (genvar i = 0; i < NB; i++) begin : g_sr
    assign sr[i] = sb[SR_SRC[i]];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign nxt = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lane (forward substitution table).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0x00 sits in the top byte, so entry a starts at bit 8*(255-a)+7.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{~a, 3'b111} -: 8];

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes: one S-box lane per state byte.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic [0:NB-1][7:0] a,
  output logic [0:NB-1][7:0] y
);

  for (genvar g = 0; g < NB; g++) begin : g_lane
    aes_sbox u_sbox (.a(a[g]), .y(y[g]));
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption, one round per clock, external round-key store.
// Define AES_ABORT_EN to add the abort port (drops RUN/DONE back to IDLE).
module aes_round_engine
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
`ifdef AES_ABORT_EN
  ,
  input  logic                abort
`endif
);

  aes_state_e          fsm_q, fsm_d;
  logic [RK_IDX_W-1:0] round_q, round_d;
  logic [127:0]        st_q, st_d, dp_nxt;
  logic                last, abort_i;

`ifdef AES_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign last = (round_q == RK_IDX_W'(NR));

  aes_round_dp u_dp (.st(st_q), .rk(rk_in), .last(last), .nxt(dp_nxt));

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    st_d    = st_q;
    case (fsm_q)
      IDLE: if (in_valid) begin
        st_d    = in_data ^ rk_in;
        round_d = RK_IDX_W'(1);
        fsm_d   = RUN;
      end
      RUN: begin
        st_d = dp_nxt;
        if (last) fsm_d = DONE;
        else      round_d = round_q + RK_IDX_W'(1);
      end
      DONE: if (out_ready) begin
        fsm_d   = IDLE;
        round_d = '0;
      end
      default: fsm_d = IDLE;
    endcase
    // Abort discards the in-flight block entirely.
    if (abort_i && fsm_q != IDLE) begin
      fsm_d   = IDLE;
      round_d = '0;
      st_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      st_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      st_q    <= st_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == RUN);
  assign out_valid = (fsm_q == DONE);
  assign out_data  = st_q;
  assign rk_idx    = (fsm_q == RUN) ? round_q : '0;

  rk_idx_range: assert property (@(posedge clk) disable iff (!rst_n) rk_idx <= RK_IDX_W'(NR));

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: FIPS-197 vectors, handshake and reset/abort corners.
module tb_aes_round_engine;
  import aes_pkg::*;

  logic                clk = 1'b0, rst_n = 1'b0;
  logic                in_valid = 1'b0, out_ready = 1'b1;
  logic                in_ready, out_valid, busy;
  logic [127:0]        in_data = '0, rk_in, out_data;
  logic [RK_IDX_W-1:0] rk_idx;
`ifdef AES_ABORT_EN
  logic                abort = 1'b0;
`endif

  int checks = 0, errors = 0;
  logic [127:0] rk_tab [0:15];
  logic [7:0]   sbox_m [0:255];

  typedef struct {
    string        nm;
    logic [127:0] key, pt, ct;
  } vec_t;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  assign rk_in = rk_tab[rk_idx];

  always #5 clk = ~clk;

  aes_round_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk_in(rk_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
`ifdef AES_ABORT_EN
    , .abort(abort)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference S-box from the field inverse plus affine map, independent of the RTL table.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick;
      n++;
    end
    chk({nm, "_ready"}, in_ready, 1'b1);
  endtask

  // Offers one block; returns at the falling edge after the accepting edge.
  task automatic start_vec(input string nm, input logic [127:0] key, input logic [127:0] pt);
    load_key(key);
    wait_ready(nm);
    chk({nm, "_rk0"}, rk_idx, 0);
    in_valid = 1'b1;
    in_data  = pt;
    tick;
    in_valid = 1'b0;
  endtask

  // Walks rounds 1..NR, then checks ciphertext at accept+NR; optionally completes the transfer.
  task automatic finish_vec(input string nm, input logic [127:0] ct, input bit hs);
    int bad = 0;
    for (int k = 1; k <= NR; k++) begin
      if (rk_idx !== k || busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      tick;
    end
    chk({nm, "_rkseq"}, bad, 0);
    chk({nm, "_ovalid"}, out_valid, 1'b1);
    chk({nm, "_ct"}, out_data, ct);
    if (hs) begin
      tick;
      chk({nm, "_drain"}, {out_valid, in_ready}, 2'b01);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [3];
    int   bad;

    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    vecs[0] = '{"c1",   KEY_C1, PT_C1, CT_C1};
    vecs[1] = '{"fipsb", KEY_B, PT_B,  CT_B};
    vecs[2] = '{"zero", '0,     '0,    CT_Z};

    // Reset state
    @(negedge clk);
    tick;
    tick;
    chk("rst_flags", {out_valid, busy, in_ready}, 3'b001);
    chk("rst_data", out_data, '0);
    chk("rst_rkidx", rk_idx, 0);
    rst_n = 1'b1;

    // Table of known-answer vectors with the consumer always ready
    for (int v = 0; v < 3; v++) begin
      start_vec(vecs[v].nm, vecs[v].key, vecs[v].pt);
      finish_vec(vecs[v].nm, vecs[v].ct, 1'b1);
    end

    // Backpressure: result must hold for 20 cycles with the input side closed
    out_ready = 1'b0;
    start_vec("bp", KEY_C1, PT_C1);
    finish_vec("bp", CT_C1, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_valid !== 1'b1 || out_data !== CT_C1 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("bp_hold", bad, 0);
    out_ready = 1'b1;
    tick;
    chk("bp_xfer", {out_valid, in_ready}, 2'b01);

    // Back-to-back: in_valid stays high, second block taken the cycle after the handshake
    load_key(KEY_C1);
    wait_ready("b2b");
    in_valid = 1'b1;
    in_data  = PT_C1;
    tick;
    in_data  = PT_B;
    finish_vec("b2b_a", CT_C1, 1'b0);
    load_key(KEY_B);
    tick;
    chk("b2b_idle", {out_valid, in_ready}, 2'b01);
    tick;
    in_valid = 1'b0;
    chk("b2b_accept", {busy, rk_idx}, {1'b1, RK_IDX_W'(1)});
    finish_vec("b2b_b", CT_B, 1'b1);

    // Reset in the middle of round 5, then a clean run
    start_vec("mrst", KEY_C1, PT_C1);
    for (int i = 0; i < 4; i++) tick;
    chk("mrst_round5", rk_idx, 5);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mrst_flags", {out_valid, busy, in_ready}, 3'b001);
    start_vec("post_rst", KEY_C1, PT_C1);
    finish_vec("post_rst", CT_C1, 1'b1);

`ifdef AES_ABORT_EN
    // Abort during round 3 drops the block; the next one must be unaffected
    start_vec("abort", KEY_B, PT_B);
    tick;
    tick;
    chk("abort_round3", rk_idx, 3);
    abort = 1'b1;
    chk("abort_cycle_ready", in_ready, 1'b0);
    tick;
    abort = 1'b0;
    chk("abort_flags", {out_valid, busy, in_ready}, 3'b001);
    chk("abort_data", out_data, '0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick;
    end
    chk("abort_no_out", bad, 0);
    start_vec("post_abort", '0, '0);
    finish_vec("post_abort", CT_Z, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
